// File: rtl/life_pkg.sv
// Shared state encoding and default rule masks for the Life stencil evaluator.
// Default masks give Conway's B3/S23 rule.
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_t;

  localparam logic [8:0] BIRTH_DEFAULT   = 9'b000001000;
  localparam logic [8:0] SURVIVE_DEFAULT = 9'b000001100;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/life_rule.sv
// Combinational next-state rule for one cell from its 3x3 window and grid-edge flags.
// Window is row-major: [0..2] row above, [3..5] centre row (bit 4 = centre), [6..8] row below.
module life_rule
  import life_pkg::*;
(
  input  logic [8:0] i_win,
  input  logic       i_edge_l,
  input  logic       i_edge_r,
  input  logic       i_edge_t,
  input  logic       i_edge_b,
  input  logic [8:0] i_birth,
  input  logic [8:0] i_survive,
  output logic       o_next
);

  logic [8:0]       w_keep;
  logic [CNT_W-1:0] w_count;

  // Neighbours that fall outside the grid are treated as dead.
  always_comb begin
    w_keep  = '0;
    w_count = '0;
    for (int i = 0; i < 9; i++) begin
      w_keep[i] = 1'b1;
      if ((i / 3) == 0 && i_edge_t) w_keep[i] = 1'b0;
      if ((i / 3) == 2 && i_edge_b) w_keep[i] = 1'b0;
      if ((i % 3) == 0 && i_edge_l) w_keep[i] = 1'b0;
      if ((i % 3) == 2 && i_edge_r) w_keep[i] = 1'b0;
      if (i != 4 && w_keep[i] && i_win[i]) begin
        w_count = w_count + CNT_W'(1);
      end
    end
  end

  assign o_next = i_win[4] ? i_survive[w_count] : i_birth[w_count];

endmodule

// File: rtl/life_stencil.sv
// Streaming Life next-generation evaluator: raster-order cells in, raster-order next state out.
// Output registered one cycle after input k+X+1 is accepted; in_ready drops for the X+1 cycle flush.
module life_stencil
  import life_pkg::*;
#(
  parameter int         X       = 8,
  parameter int         Y       = 8,
  parameter int         LOG2X   = 3,
  parameter int         LOG2Y   = 3,
  parameter logic [8:0] BIRTH   = BIRTH_DEFAULT,
  parameter logic [8:0] SURVIVE = SURVIVE_DEFAULT
)(
  input  logic clk,
  input  logic reset,
  input  logic new_data,
  input  logic in_valid,
  input  logic frame_start,
  output logic in_ready,
  output logic out_data,
  output logic out_valid,
  output logic out_last
);

  localparam int                SR_W     = 2 * X + 2;
  localparam logic [LOG2X-1:0]  COL_LAST = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0]  ROW_LAST = LOG2Y'(Y - 1);

  state_t            r_state;
  state_t            w_state_nxt;

  // r_sr[i] holds input n-1-i: two row delay lines plus the two window columns behind the new bit.
  logic [SR_W-1:0]   r_sr;
  logic [LOG2X-1:0]  r_in_col;
  logic [LOG2Y-1:0]  r_in_row;
  logic [LOG2X-1:0]  r_cx;
  logic [LOG2Y-1:0]  r_cy;
  logic              r_out_data;
  logic              r_out_valid;
  logic              r_out_last;

  logic              w_accept;
  logic              w_start;
  logic              w_shift;
  logic              w_emit;
  logic              w_flush;
  logic              w_in_bit;
  logic              w_in_fill_end;
  logic              w_in_last;
  logic              w_c_last;
  logic [8:0]        w_win;
  logic              w_next;

  assign in_ready = (r_state != ST_FLUSH);
  assign w_accept = in_valid && (r_state != ST_FLUSH);
  assign w_start  = w_accept && frame_start;
  assign w_in_bit = w_flush ? 1'b0 : new_data;

  assign w_in_fill_end = (r_in_col == '0) && (r_in_row == LOG2Y'(1));
  assign w_in_last     = (r_in_col == COL_LAST) && (r_in_row == ROW_LAST);
  assign w_c_last      = (r_cx == COL_LAST) && (r_cy == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_emit      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_shift     = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_accept) begin
          w_shift = 1'b1;
          if (!frame_start && w_in_fill_end) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_shift = 1'b1;
          if (frame_start) begin
            w_state_nxt = ST_FILL;
          end else begin
            w_emit = 1'b1;
            if (w_in_last) w_state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        w_flush = 1'b1;
        w_shift = 1'b1;
        w_emit  = 1'b1;
        if (w_c_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Input position tracks the next expected cell; centre position tracks the next output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_col <= '0;
      r_in_row <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
    end else if (w_start) begin
      r_in_col <= LOG2X'(1);
      r_in_row <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
    end else begin
      if (w_accept && (r_state == ST_FILL || r_state == ST_RUN)) begin
        if (r_in_col == COL_LAST) begin
          r_in_col <= '0;
          r_in_row <= r_in_row + LOG2Y'(1);
        end else begin
          r_in_col <= r_in_col + LOG2X'(1);
        end
      end
      if (w_emit) begin
        if (r_cx == COL_LAST) begin
          r_cx <= '0;
          r_cy <= r_cy + LOG2Y'(1);
        end else begin
          r_cx <= r_cx + LOG2X'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else if (w_shift) begin
      r_sr <= {r_sr[SR_W-2:0], w_in_bit};
    end
  end

  assign w_win[0] = r_sr[2*X+1];
  assign w_win[1] = r_sr[2*X];
  assign w_win[2] = r_sr[2*X-1];
  assign w_win[3] = r_sr[X+1];
  assign w_win[4] = r_sr[X];
  assign w_win[5] = r_sr[X-1];
  assign w_win[6] = r_sr[1];
  assign w_win[7] = r_sr[0];
  assign w_win[8] = w_in_bit;

  life_rule u_rule (
    .i_win     (w_win),
    .i_edge_l  (r_cx == '0),
    .i_edge_r  (r_cx == COL_LAST),
    .i_edge_t  (r_cy == '0),
    .i_edge_b  (r_cy == ROW_LAST),
    .i_birth   (BIRTH),
    .i_survive (SURVIVE),
    .o_next    (w_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      r_out_data  <= w_emit && w_next;
      r_out_last  <= w_emit && w_flush && w_c_last;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_life_stencil.sv
// Scoreboard bench for life_stencil on an 8x8 grid.
module tb_life_stencil;

  logic clk = 1'b0;
  logic reset;
  logic new_data;
  logic in_valid;
  logic frame_start;
  logic in_ready;
  logic out_data;
  logic out_valid;
  logic out_last;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  int last_count = 0;
  int low_run = 0;
  logic prev_acc = 1'b0;
  logic prev_busy = 1'b0;
  logic [1:0] exp_q[$];

  life_stencil #(
    .X(8), .Y(8), .LOG2X(3), .LOG2Y(3),
    .BIRTH(9'b000001000), .SURVIVE(9'b000001100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .new_data    (new_data),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  function automatic int pos(input int x, input int y);
    return y * 8 + x;
  endfunction

  function automatic logic [63:0] next_gen(input logic [63:0] g);
    logic [63:0] r;
    int c;
    r = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        c = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8)
              c += int'(g[(y + dy) * 8 + x + dx]);
          end
        end
        r[y * 8 + x] = g[y * 8 + x] ? (c == 2 || c == 3) : (c == 3);
      end
    end
    return r;
  endfunction

  // Output monitor: scoreboard pop, stall rule and flush-bubble length.
  always @(negedge clk) begin
    logic [1:0] e;
    if (out_valid === 1'b1) begin
      out_count++;
      if (out_last === 1'b1) last_count++;
      checks++;
      if (!(prev_acc || prev_busy)) begin
        errors++;
        $display("FAIL stall_output: out_valid=1 after a cycle with no accept and no flush");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got data=%0b last=%0b, expected no output", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_last} !== e) begin
          errors++;
          $display("FAIL output_cell #%0d: got data=%0b last=%0b, expected data=%0b last=%0b",
                   out_count - 1, out_data, out_last, e[1], e[0]);
        end
      end
    end
    if (in_ready === 1'b0) begin
      low_run++;
    end else if (low_run > 0) begin
      checks++;
      if (low_run != 9) begin
        errors++;
        $display("FAIL flush_bubble: in_ready low for %0d cycles, expected 9", low_run);
      end
      low_run = 0;
    end
    prev_acc  = (in_valid === 1'b1) && (in_ready === 1'b1) && (reset === 1'b0);
    prev_busy = (in_ready === 1'b0);
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    frame_start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic d, input logic fs);
    int guard;
    guard = 0;
    new_data = d;
    frame_start = fs;
    in_valid = 1'b1;
    while (in_ready !== 1'b1) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 100) begin
        errors++;
        $display("FAIL in_ready_timeout: in_ready stuck at %0b, expected 1 within 100 cycles", in_ready);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "in_ready timeout");
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic push_grid(input logic [63:0] ex, input int n_out);
    for (int k = 0; k < n_out; k++) exp_q.push_back({ex[k], (k == 63)});
  endtask

  task automatic send_frame(input logic [63:0] g, input int gap_pct);
    for (int k = 0; k < 64; k++) begin
      if (gap_pct > 0) begin
        while ($urandom_range(99) < gap_pct) idle(1);
      end
      send(g[k], (k == 0));
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still pending, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    new_data = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
    checks++;
    if (out_data !== 1'b0) begin errors++; $display("FAIL reset_out_data: got %0b, expected 0", out_data); end
    checks++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b, expected 0", out_last); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_idle_discard();
    int oc0;
    oc0 = out_count;
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    idle(15);
    checks++;
    if (out_count != oc0) begin
      errors++;
      $display("FAIL idle_discard: got %0d outputs, expected 0", out_count - oc0);
    end
  endtask

  task automatic test_directed(input string name, input logic [63:0] g, input logic [63:0] ex);
    int oc0, lc0;
    oc0 = out_count;
    lc0 = last_count;
    push_grid(ex, 64);
    send_frame(g, 0);
    wait_drain();
    checks++;
    if (out_count - oc0 != 64) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs, expected 64", name, out_count - oc0);
    end
    checks++;
    if (last_count - lc0 != 1) begin
      errors++;
      $display("FAIL %s_last: got %0d out_last pulses, expected 1", name, last_count - lc0);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] g1, g2;
    int oc0, lc0;
    g1 = {$urandom, $urandom};
    g2 = {$urandom, $urandom};
    oc0 = out_count;
    lc0 = last_count;
    push_grid(next_gen(g1), 64);
    push_grid(next_gen(g2), 64);
    send_frame(g1, 30);
    send_frame(g2, 30);
    wait_drain();
    checks++;
    if (out_count - oc0 != 128) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs, expected 128", out_count - oc0);
    end
    checks++;
    if (last_count - lc0 != 2) begin
      errors++;
      $display("FAIL b2b_last: got %0d out_last pulses, expected 2", last_count - lc0);
    end
  endtask

  task automatic test_abort(input logic [63:0] blink, input logic [63:0] blink_ex);
    logic [63:0] a, ax;
    int oc0, lc0;
    a = {$urandom, $urandom};
    ax = next_gen(a);
    oc0 = out_count;
    lc0 = last_count;
    for (int k = 0; k <= 10; k++) exp_q.push_back({ax[k], 1'b0});
    for (int k = 0; k < 20; k++) send(a[k], (k == 0));
    push_grid(blink_ex, 64);
    send_frame(blink, 0);
    wait_drain();
    checks++;
    if (out_count - oc0 != 75) begin
      errors++;
      $display("FAIL abort_count: got %0d outputs, expected 75", out_count - oc0);
    end
    checks++;
    if (last_count - lc0 != 1) begin
      errors++;
      $display("FAIL abort_last: got %0d out_last pulses, expected 1", last_count - lc0);
    end
  endtask

  task automatic test_reset_mid(input logic [63:0] blink, input logic [63:0] blink_ex);
    logic [63:0] a, ax;
    int oc0, lc0;
    a = {$urandom, $urandom};
    ax = next_gen(a);
    oc0 = out_count;
    lc0 = last_count;
    for (int k = 0; k <= 30; k++) exp_q.push_back({ax[k], 1'b0});
    for (int k = 0; k < 40; k++) send(a[k], (k == 0));
    reset = 1'b1;
    in_valid = 1'b1;
    new_data = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %0b, expected 0", out_valid); end
    checks++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL rstmid_out_last: got %0b, expected 0", out_last); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %0b, expected 1", in_ready); end
    reset = 1'b0;
    idle(20);
    checks++;
    if (out_count - oc0 != 31 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_count: got %0d outputs (%0d pending), expected 31 (0 pending)",
               out_count - oc0, exp_q.size());
    end
    checks++;
    if (last_count != lc0) begin
      errors++;
      $display("FAIL rstmid_last: got %0d out_last pulses, expected 0", last_count - lc0);
    end
    exp_q.delete();
    test_directed("recover", blink, blink_ex);
  endtask

  initial begin
    logic [63:0] g, ex, blink, blink_ex;

    test_reset();
    test_idle_discard();

    g = '0;
    g[pos(3, 3)] = 1'b1;
    test_directed("single", g, 64'h0);

    g = '0;
    g[pos(3, 3)] = 1'b1; g[pos(4, 3)] = 1'b1;
    g[pos(3, 4)] = 1'b1; g[pos(4, 4)] = 1'b1;
    test_directed("block", g, g);

    blink = '0;
    blink[pos(2, 4)] = 1'b1; blink[pos(3, 4)] = 1'b1; blink[pos(4, 4)] = 1'b1;
    blink_ex = '0;
    blink_ex[pos(3, 3)] = 1'b1; blink_ex[pos(3, 4)] = 1'b1; blink_ex[pos(3, 5)] = 1'b1;
    test_directed("blinker", blink, blink_ex);

    g = '1;
    ex = '0;
    ex[pos(0, 0)] = 1'b1; ex[pos(7, 0)] = 1'b1;
    ex[pos(0, 7)] = 1'b1; ex[pos(7, 7)] = 1'b1;
    test_directed("all_ones", g, ex);

    test_back_to_back();
    test_abort(blink, blink_ex);
    test_reset_mid(blink, blink_ex);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_stencil.md
Name: life_stencil

Overview:
- Streaming next-generation evaluator for the Life grid.
- Consumes current-generation cells one bit per accepted cycle in raster order (row 0 col 0 first; X columns per row, Y rows).
- Builds a 3x3 neighbourhood from two internal X-bit row delay lines plus a 3-column window.
- Emits the next-generation bit per cell in the same raster order. Sits directly downstream of the row delay pipe that feeds the cell stream.

Parameters:
- X, 8: grid width in cells.
- Y, 8: grid height in cells.
- LOG2X, 3: column counter width; X <= 2**LOG2X.
- LOG2Y, 3: row counter width; Y <= 2**LOG2Y.
- BIRTH, 9'b000001000: bit n set means a dead cell with n live neighbours is born (B3).
- SURVIVE, 9'b000001100: bit n set means a live cell with n live neighbours survives (S23).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- new_data  input  1  current-generation cell bit.
- in_valid  input  1  new_data is valid this cycle.
- frame_start  input  1  qualifies new_data as cell (0,0); sampled only with in_valid.
- in_ready  output  1  block accepts input this cycle. Transfer occurs when in_valid && in_ready.
- out_data  output  1  next-generation cell bit.
- out_valid  output  1  out_data valid; single-cycle pulse per cell. No backpressure.
- out_last  output  1  asserted with out_valid on cell (X-1,Y-1).

Behaviour:
- Reset state:
  - in_ready=1, out_valid=0, out_data=0, out_last=0.
  - Row delay lines, window and counters cleared to 0.
  - FSM in IDLE.
- FSM states:
  - IDLE: inputs without frame_start are discarded (in_ready=1). An accepted frame_start loads input index n=0 and enters FILL.
  - FILL: accepting inputs n=1..X. No outputs. After n=X is accepted, enter RUN.
  - RUN: each accepted input n (n>X) produces output for centre index k=n-X-1. After n=X*Y-1 is accepted, enter FLUSH.
  - FLUSH:
    - in_ready=0.
    - Block injects X+1 internal zero cells, one per cycle, each producing one output.
    - The output with k=X*Y-1 carries out_last; then return to IDLE.
- Latency:
  - Output for centre k is registered, valid one cycle after acceptance of input k+X+1, or after its flush injection.
  - Gaps in in_valid stall the pipeline; no outputs are produced during stalls.
- Exactly X*Y outputs per frame.
- Boundary (dead edges, no wrap). With centre column cx=k mod X and row cy=k div X:
  - Left column neighbours forced 0 when cx==0.
  - Right column neighbours forced 0 when cx==X-1.
  - Top row neighbours forced 0 when cy==0.
  - Bottom row neighbours forced 0 when cy==Y-1.
  - Masking is by counters, never by relying on delay-line contents from a previous frame.
- Rule:
  - count = sum of 8 masked neighbours, 4 bits (0..8).
  - next = centre ? SURVIVE[count] : BIRTH[count].
- frame_start mid-frame:
  - In FILL or RUN, an accepted frame_start aborts the current frame.
  - No further outputs from the aborted frame; out_last is not emitted for it.
  - Counters restart with this input as n=0; FSM enters FILL.
- frame_start during FLUSH: cannot occur, since in_ready=0.
- Input arriving on the cycle FLUSH ends: in_ready returns to 1 in IDLE. Back-to-back frames are allowed with an X+1 cycle flush bubble.
- reset mid-operation: discards the frame; outputs go to reset values next cycle.

Decomposition:
- Package life_pkg:
  - FSM state enum (IDLE, FILL, RUN, FLUSH).
  - Default BIRTH/SURVIVE masks.
  - Neighbour-count width constant (4).
- Sub-module life_rule: combinational; inputs are the 3x3 window, 4 edge-mask bits, BIRTH/SURVIVE; output is the next-state bit.
- Counters, delay lines and FSM live in life_stencil.

Test Plan:
- Single live cell at (3,3), 8x8 grid -> 64 out_valid pulses, all out_data=0, out_last on 64th only.
- Block still life (3,3),(4,3),(3,4),(4,4) -> output identical to input.
- Horizontal blinker (2..4,4) -> output vertical blinker (3,3),(3,4),(3,5) only.
- All-ones frame -> only corners (0,0),(7,0),(0,7),(7,7) live; verifies edge masking and 3/5/8 counts.
- Two back-to-back frames with random in_valid gaps (~30% idle) -> each frame's output matches the reference model. No outputs during stalls; in_ready=0 for exactly 9 cycles per flush.
- frame_start reasserted at input n=20, then a full blinker frame -> only 64 outputs of the blinker result. Reset asserted at n=40 of a further frame -> out_valid=0 next cycle, no out_last.
